// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Instruction-memory responder for the fetch stage. In normal operation it
// returns the word at the fetch address one cycle later. A byte-stream load
// port (valid/ready) rewrites the memory; during a load the core is held and
// NOPs are returned.
//
// Ports:
//   clk                 clock, rising edge
//   rst_n               asynchronous active-low reset
//   instruction_addr_i  fetch byte address (bits [1:0] ignored)
//   instruction_rdata_o registered instruction word
//   load_start_i        single-cycle load request
//   load_len_i          number of words to load (sampled with load_start_i)
//   load_byte_i         program byte, little-endian within a word
//   load_valid_i        load_byte_i is valid
//   load_ready_o        a byte is accepted this cycle
//   load_done_o         one-cycle pulse when a load completes
//   core_hold_o         holds the core while loading
// -----------------------------------------------------------------------------
module imem_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] instruction_addr_i,
   output logic [DATA_WIDTH-1:0] instruction_rdata_o,
   input  logic                  load_start_i,
   input  logic [ADDR_WIDTH-2:0] load_len_i,
   input  logic [7:0]            load_byte_i,
   input  logic                  load_valid_i,
   output logic                  load_ready_o,
   output logic                  load_done_o,
   output logic                  core_hold_o
);

   localparam int WORD_AW = ADDR_WIDTH - 2;
   localparam int DEPTH   = 1 << WORD_AW;
   localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);
   localparam logic [ADDR_WIDTH-2:0] DEPTH_L = (ADDR_WIDTH-1)'(DEPTH);
   localparam logic [ADDR_WIDTH-2:0] ONE_L   = (ADDR_WIDTH-1)'(1);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_r;
   logic [WORD_AW-1:0]      word_ptr_r;
   logic [WORD_AW-1:0]      last_ptr_r;
   logic [1:0]              byte_cnt_r;
   logic [DATA_WIDTH-9:0]   asm_r;
   logic [DATA_WIDTH-1:0]   rdata_r;
   logic                    ready_r;
   logic                    done_r;
   logic                    hold_r;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    accept_s;
   logic                    word_done_s;
   logic [DATA_WIDTH-1:0]   full_word_s;
   logic [WORD_AW-1:0]      last_ptr_s;
   logic [WORD_AW-1:0]      rd_idx_s;
   logic [1:0]              addr_unused_s;

   // Byte acceptance, word completion and the clamped index of the final word.
   always_comb begin
      accept_s      = load_valid_i & ready_r;
      word_done_s   = accept_s & (byte_cnt_r == 2'd3);
      full_word_s   = {load_byte_i, asm_r};
      rd_idx_s      = instruction_addr_i[ADDR_WIDTH-1:2];
      addr_unused_s = instruction_addr_i[1:0];
      // Lengths beyond the array are clamped so word_ptr never wraps.
      if (load_len_i > DEPTH_L) begin
         last_ptr_s = WORD_AW'(DEPTH_L - ONE_L);
      end else begin
         last_ptr_s = WORD_AW'(load_len_i - ONE_L);
      end
   end

   // Control FSM with registered outputs and the read-data register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_RUN;
         word_ptr_r <= '0;
         last_ptr_r <= '0;
         byte_cnt_r <= 2'd0;
         asm_r      <= '0;
         rdata_r    <= NOP;
         ready_r    <= 1'b0;
         done_r     <= 1'b0;
         hold_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_RUN: begin
               rdata_r <= mem[rd_idx_s];
               if (load_start_i) begin
                  if (load_len_i == '0) begin
                     // Empty load: acknowledge without holding the core.
                     done_r <= 1'b1;
                  end else begin
                     state_r    <= ST_LOAD;
                     word_ptr_r <= '0;
                     byte_cnt_r <= 2'd0;
                     last_ptr_r <= last_ptr_s;
                     ready_r    <= 1'b1;
                     hold_r     <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               rdata_r <= NOP;
               if (accept_s) begin
                  if (byte_cnt_r == 2'd3) begin
                     byte_cnt_r <= 2'd0;
                     if (word_ptr_r == last_ptr_r) begin
                        state_r <= ST_DONE;
                        ready_r <= 1'b0;
                        done_r  <= 1'b1;
                     end else begin
                        word_ptr_r <= word_ptr_r + WORD_AW'(1);
                     end
                  end else begin
                     asm_r[8*byte_cnt_r +: 8] <= load_byte_i;
                     byte_cnt_r <= byte_cnt_r + 2'd1;
                  end
               end
            end
            ST_DONE: begin
               rdata_r <= NOP;
               state_r <= ST_RUN;
               ready_r <= 1'b0;
               hold_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_RUN;
               rdata_r <= NOP;
               ready_r <= 1'b0;
               hold_r  <= 1'b0;
            end
         endcase
      end
   end

   // Memory write port: one write per completed word; the array is never reset.
   always_ff @(posedge clk) begin
      if (word_done_s) begin
         mem[word_ptr_r] <= full_word_s;
      end
   end

   assign instruction_rdata_o = rdata_r;
   assign load_ready_o        = ready_r;
   assign load_done_o         = done_r;
   assign core_hold_o         = hold_r;

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the fetch-side interface.
- Serves the fetch stage's instruction address with a registered, one-cycle-latency instruction word.
- Contains a byte-stream program-load port with a valid/ready handshake, used at boot or reprogramming time.
- While a load is in progress it holds the core through core_hold_o, which feeds the core's general stall, and it returns NOPs.

Parameters:
- ADDR_WIDTH, 12, byte-address width of instruction_addr_i; depth = 2^(ADDR_WIDTH-2) words.
- DATA_WIDTH, 32, instruction word width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active low.
- instruction_addr_i  input  ADDR_WIDTH  byte address from the fetch stage; bits [1:0] are ignored.
- instruction_rdata_o  output  32  registered instruction word.
- load_start_i  input  1  single-cycle request to begin a program load.
- load_len_i  input  ADDR_WIDTH-1  number of words to load; sampled with load_start_i.
- load_byte_i  input  8  program byte, little-endian within each word.
- load_valid_i  input  1  load_byte_i is valid.
- load_ready_o  output  1  responder accepts a byte this cycle.
- load_done_o  output  1  single-cycle pulse when a load completes.
- core_hold_o  output  1  high holds the core (to stall_general).

Behaviour:
- Reset values:
  - instruction_rdata_o = 0x00000013 (NOP).
  - load_ready_o = 0, load_done_o = 0, core_hold_o = 0.
  - FSM = RUN; byte and word counters = 0.
  - Memory array is not reset; its contents are retained across rst_n and undefined at power-up.
- States: RUN, LOAD, DONE.
- RUN:
  - Each cycle, instruction_rdata_o <= mem[instruction_addr_i[ADDR_WIDTH-1:2]]. Data appears on the cycle after the address (latency 1, no stall input). The fetch stage handles stall replay itself.
  - load_start_i with load_len_i == 0: no state change; load_done_o pulses on the next cycle; core_hold_o stays 0.
  - load_start_i with load_len_i != 0: go to LOAD. Set word_ptr = 0, byte_cnt = 0, len_q = min(load_len_i, depth).
- LOAD:
  - core_hold_o = 1, load_ready_o = 1.
  - instruction_rdata_o <= 0x00000013 every cycle; instruction_addr_i is ignored.
  - A byte is accepted when load_valid_i & load_ready_o. byte_cnt indexes lanes 0..3; lane k fills bits [8k+7:8k] of a 32-bit assembly register.
  - On acceptance with byte_cnt == 3:
    - write the assembled word to mem[word_ptr]; byte_cnt <= 0; word_ptr <= word_ptr + 1.
    - if word_ptr == len_q-1, go to DONE instead.
  - Cycles with valid low are idle, and arbitrarily long gaps are allowed.
  - load_start_i in LOAD is ignored.
- DONE:
  - Lasts exactly one cycle: load_done_o = 1, core_hold_o = 1, load_ready_o = 0, rdata = NOP. Then go to RUN.
  - The first RUN read returns newly loaded content. A fetch of address 0 issued in the first RUN cycle yields the new mem[0] one cycle later.
  - load_start_i in DONE is ignored.
- Clamping: len_q never exceeds depth, and word_ptr never wraps during a load.
- Reset mid-load:
  - Immediate return to RUN; outputs go to their reset values.
  - Words already written remain in memory; a partially assembled word is discarded and not written.
  - load_done_o is not pulsed.
- Exactly one memory write per completed word. No write ever occurs in RUN.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → rdata_o=0x00000013, core_hold_o=0, load_ready_o=0 immediately (async); the first RUN read after release returns mem contents one cycle after the address.
- Load and read: load_len=2, bytes 13 00 00 00 93 00 10 00 back-to-back.
  - Required: core_hold_o=1 from the cycle after start through DONE; load_done_o pulses once, 1 cycle after the 8th byte.
  - Then addr 0x000 → 0x00000013 and addr 0x004 → 0x00100093, each on the next cycle.
  - Addr 0x006 reads 0x00100093 (bits [1:0] ignored).
- Backpressure: the same 2-word load with load_valid_i toggled 1,0,0,1,… randomly → identical memory contents; rdata_o = NOP throughout LOAD regardless of address.
- Zero length: load_start_i with load_len=0 → no hold, load_done_o pulse next cycle, memory unchanged.
- Reset mid-load: load_len=2, 5 bytes accepted, then rst_n pulse → word 0 updated; word 1 keeps its previous value; FSM in RUN; no load_done_o.
- Clamp: ADDR_WIDTH=4 (depth 4), load_len=7 → exactly 16 bytes accepted, then DONE; load_ready_o=0 afterward; words 0..3 written.
